// File: rtl/rprelu_param_loader.sv
// Parameter loader for the RPReLU stage: streams beta/gamma/zeta words out of the parameter
// SRAM into per-channel banks and only forwards upstream valids while those banks are stable.
module rprelu_param_loader #(
  parameter int PARA_WIDTH  = 16,
  parameter int CHANNEL_NUM = 128,
  parameter int ADDR_WIDTH  = 9,
  parameter int PIPE_LAT    = 3
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  output logic                                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  input  logic [PARA_WIDTH-1:0]                  mem_rd_data,
  input  logic                                   up_valid,
  output logic                                   rprelu_valid,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] beta,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] gamma,
  output logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] zeta,
  output logic                                   params_ready,
  output logic                                   busy,
  output logic [15:0]                            drop_cnt
);

  localparam int NWORDS = 3 * CHANNEL_NUM;
  localparam int DW     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_K     = ADDR_WIDTH'(NWORDS - 1);
  localparam logic [DW-1:0]         DRAIN_INIT = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, READY, DRAIN} state_e;

  state_e                                 state_q;
  logic [ADDR_WIDTH-1:0]                  k_q;
  logic [DW-1:0]                          drain_q;
  logic                                   rd_en_q;
  logic [ADDR_WIDTH-1:0]                  raddr_q;
  logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] beta_q, gamma_q, zeta_q;
  logic [15:0]                            drop_q, drop_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= FETCH;
          k_q     <= '0;
        end
        FETCH: begin
          k_q <= k_q + ADDR_WIDTH'(1);
          if (k_q == LAST_K) state_q <= LAST;
        end
        LAST:  state_q <= READY;
        READY: if (start) begin
          state_q <= DRAIN;
          drain_q <= DRAIN_INIT;
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= FETCH;
            k_q     <= '0;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en    = (state_q == FETCH);
  assign mem_addr     = k_q;
  assign params_ready = (state_q == READY);
  assign busy         = (state_q != IDLE) && (state_q != READY);
  assign rprelu_valid = up_valid && (state_q == READY);

  // SRAM data lags the address by one cycle, so the write uses the delayed address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_en_q <= 1'b0;
      raddr_q <= '0;
      beta_q  <= '0;
      gamma_q <= '0;
      zeta_q  <= '0;
    end else begin
      rd_en_q <= mem_rd_en;
      raddr_q <= mem_addr;
      if (rd_en_q) begin
        for (int c = 0; c < CHANNEL_NUM; c++) begin
          if (raddr_q == ADDR_WIDTH'(c))                 beta_q[c]  <= mem_rd_data;
          if (raddr_q == ADDR_WIDTH'(CHANNEL_NUM + c))   gamma_q[c] <= mem_rd_data;
          if (raddr_q == ADDR_WIDTH'(2*CHANNEL_NUM + c)) zeta_q[c]  <= mem_rd_data;
        end
      end
    end
  end

  assign beta  = beta_q;
  assign gamma = gamma_q;
  assign zeta  = zeta_q;

  always_comb begin
    drop_d = drop_q;
    if (up_valid && (state_q != READY) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_rprelu_param_loader.sv
// Directed + randomized bench for rprelu_param_loader with a schedule-based reference model.
module tb_rprelu_param_loader;

  localparam int CH = 4;
  localparam int NW = 3 * CH;
  localparam int PL = 3;

  logic                  clk;
  logic                  rstn;
  logic                  start;
  logic                  mem_rd_en;
  logic [8:0]            mem_addr;
  logic [15:0]           mem_rd_data;
  logic                  up_valid;
  logic                  rprelu_valid;
  logic [CH-1:0][15:0]   beta, gamma, zeta;
  logic                  params_ready;
  logic                  busy;
  logic [15:0]           drop_cnt;

  rprelu_param_loader #(
    .PARA_WIDTH(16), .CHANNEL_NUM(CH), .ADDR_WIDTH(9), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .up_valid(up_valid), .rprelu_valid(rprelu_valid),
    .beta(beta), .gamma(gamma), .zeta(zeta),
    .params_ready(params_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] sram [NW];

  initial mem_rd_data = '0;
  always @(posedge clk) if (mem_rd_en && mem_addr < 9'(NW)) mem_rd_data <= sram[mem_addr[3:0]];

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          m_idle;
  int          m_f;
  logic [15:0] m_drop;
  logic [15:0] m_bank [NW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_banks();
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("beta[%0d]", i),  beta[i],  m_bank[i]);
      chk($sformatf("gamma[%0d]", i), gamma[i], m_bank[CH+i]);
      chk($sformatf("zeta[%0d]", i),  zeta[i],  m_bank[2*CH+i]);
    end
  endtask

  task automatic do_reset();
    start = 1'b0; up_valid = 1'b0; rstn = 1'b0;
    #1;
    m_idle = 1'b1; m_f = 0; m_drop = '0;
    for (int i = 0; i < NW; i++) m_bank[i] = '0;
    chk("rst_params_ready", params_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rprelu_valid", rprelu_valid, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    check_banks();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    cyc++;
  endtask

  // One cycle: apply inputs, compare against the load schedule, then advance the model.
  task automatic step(input bit st, input bit uv);
    bit e_rd, e_rdy;
    int a;
    start = st; up_valid = uv;
    #1;
    e_rd  = !m_idle && cyc >= m_f && cyc < m_f + NW;
    e_rdy = !m_idle && cyc >= m_f + NW + 1;
    chk("params_ready", params_ready, e_rdy);
    chk("busy", busy, !m_idle && !e_rdy);
    chk("rprelu_valid", rprelu_valid, uv && e_rdy);
    chk("mem_rd_en", mem_rd_en, e_rd);
    if (e_rd) chk("mem_addr", mem_addr, cyc - m_f);
    chk("drop_cnt", drop_cnt, m_drop);
    a = cyc - m_f - 1;
    if (!m_idle && a >= 0 && a < NW) m_bank[a] = sram[a];
    if (uv && !e_rdy && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    if (st) begin
      if (m_idle) begin
        m_idle = 1'b0;
        m_f    = cyc + 1;
      end else if (e_rdy) begin
        m_f = cyc + PL + 1;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic fast_drop(input int n);
    start = 1'b0; up_valid = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      cyc++;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; up_valid = 1'b0;
    for (int a = 0; a < NW; a++) sram[a] = 16'h0100 + 16'(a);
    do_reset();

    // basic load, start at cycle 0
    step(1'b1, 1'b0);
    repeat (15) step(1'b0, 1'b0);
    check_banks();

    // up_valid held high through the load
    do_reset();
    step(1'b1, 1'b1);
    repeat (13) step(1'b0, 1'b1);
    chk("drop_cnt_at_ready", drop_cnt, 14);
    repeat (3) step(1'b0, 1'b1);

    // reload from READY with start and up_valid together, new random contents
    for (int a = 0; a < NW; a++) sram[a] = 16'($urandom);
    step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'($urandom_range(0, 1)));
    check_banks();

    // second start during FETCH is ignored
    do_reset();
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    check_banks();

    // reset at cycle 6 of a load, then a clean reload
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    do_reset();
    for (int a = 0; a < NW; a++) sram[a] = 16'($urandom);
    step(1'b1, 1'($urandom_range(0, 1)));
    repeat (16) step(1'b0, 1'($urandom_range(0, 1)));
    check_banks();

    // random start / up_valid traffic
    repeat (200) step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    check_banks();

    // negative word kept bit-exact, drop counter saturation
    do_reset();
    for (int a = 0; a < NW; a++) sram[a] = 16'h0100 + 16'(a);
    sram[11] = 16'h8000;
    fast_drop(65534);
    repeat (4) step(1'b0, 1'b1);
    fast_drop(4458);
    chk("drop_cnt_sat", drop_cnt, 16'hFFFF);
    step(1'b1, 1'b1);
    repeat (16) step(1'b0, 1'($urandom_range(0, 1)));
    chk("drop_cnt_hold", drop_cnt, 16'hFFFF);
    chk("zeta3_neg", zeta[3], 16'h8000);
    check_banks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
